// File: rtl/midi_reg_master.sv
// MIDI byte-stream parser that turns note-on/note-off messages into
// register read/write requests against a per-channel floppy register bank.
module midi_reg_master #(
  parameter int NUM_CH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [5:0] reg_addr,
  output logic       write,
  output logic       new_req,
  output logic [7:0] write_value,
  input  logic [7:0] read_value,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_CHK, WR_REQ} state_t;

  state_t     state;
  logic       rs_valid;
  logic [3:0] rs_type;
  logic [3:0] rs_ch;
  logic       rs_two;
  logic       data_idx;
  logic [6:0] data0;
  logic [6:0] req_note;
  logic       buf_valid;
  logic [7:0] buf_data;

  // Realtime bytes never reach the parser or the holding buffer.
  logic       in_take;
  logic       parse_vld;
  logic [7:0] parse_byte;
  logic [6:0] msg_note;
  logic       is_note;
  logic       note_on;

  always_comb begin
    in_take    = new_rx_data && (rx_data < 8'hF8);
    parse_vld  = (state == IDLE) && (buf_valid || in_take);
    parse_byte = buf_valid ? buf_data : rx_data;
    msg_note   = rs_two ? data0 : parse_byte[6:0];
    is_note    = ((rs_type == 4'h8) || (rs_type == 4'h9)) && (int'(rs_ch) < NUM_CH);
    note_on    = (rs_type == 4'h9) && (parse_byte[6:0] != 7'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rs_valid    <= 1'b0;
      rs_type     <= 4'h0;
      rs_ch       <= 4'h0;
      rs_two      <= 1'b0;
      data_idx    <= 1'b0;
      data0       <= 7'd0;
      req_note    <= 7'd0;
      buf_valid   <= 1'b0;
      buf_data    <= 8'h00;
      reg_addr    <= 6'd0;
      write       <= 1'b0;
      new_req     <= 1'b0;
      write_value <= 8'h00;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      new_req <= 1'b0;

      // Holding buffer: one byte may wait while busy; a buffered byte takes
      // priority over a fresh one on the cycle it is drained.
      if (state != IDLE) begin
        if (in_take) begin
          if (buf_valid) overflow <= 1'b1;
          else begin
            buf_valid <= 1'b1;
            buf_data  <= rx_data;
          end
        end
      end else if (buf_valid) begin
        buf_valid <= 1'b0;
        if (in_take) overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (parse_vld) begin
            if (parse_byte >= 8'hF0) begin
              rs_valid <= 1'b0;
              data_idx <= 1'b0;
            end else if (parse_byte[7]) begin
              rs_valid <= 1'b1;
              rs_type  <= parse_byte[7:4];
              rs_ch    <= parse_byte[3:0];
              rs_two   <= (parse_byte[7:5] != 3'b110);
              data_idx <= 1'b0;
            end else if (rs_valid) begin
              if (rs_two && !data_idx) begin
                data0    <= parse_byte[6:0];
                data_idx <= 1'b1;
              end else begin
                data_idx <= 1'b0;
                if (is_note) begin
                  req_note <= msg_note;
                  reg_addr <= 6'(rs_ch);
                  new_req  <= 1'b1;
                  busy     <= 1'b1;
                  if (note_on) begin
                    state       <= WR_REQ;
                    write       <= 1'b1;
                    write_value <= {1'b1, msg_note};
                  end else begin
                    state <= RD_REQ;
                    write <= 1'b0;
                  end
                end
              end
            end
          end
        end
        RD_REQ: state <= RD_CHK;
        RD_CHK: begin
          // Only clear the register if it still plays the note being released.
          if (read_value == {1'b1, req_note}) begin
            state       <= WR_REQ;
            new_req     <= 1'b1;
            write       <= 1'b1;
            write_value <= {1'b0, req_note};
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WR_REQ: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_reg_master.sv
// Bench for midi_reg_master: directed vector table, hand-written corner
// sequences, and a random byte stream scored against a message-level model.
module tb_midi_reg_master;
  localparam int NUM_CH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic [5:0] reg_addr;
  logic       write;
  logic       new_req;
  logic [7:0] write_value;
  logic [7:0] read_value = 8'h00;
  logic       busy;
  logic       overflow;

  midi_reg_master #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .reg_addr(reg_addr), .write(write), .new_req(new_req),
    .write_value(write_value), .read_value(read_value),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_strobe = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] val;
    int         cyc;
  } req_t;

  req_t       obs_q[$];
  logic [7:0] rf[64] = '{default: 8'h00};
  logic       pre_go = 1'b0;
  int         pre_addr = 0;
  logic [7:0] pre_val = 8'h00;
  logic       prev_req = 1'b0;
  int         consec = 0;

  // Register-bank responder and request monitor.
  always @(negedge clk) begin
    if (pre_go) rf[pre_addr] <= pre_val;
    if (new_req) begin
      obs_q.push_back('{write, reg_addr, write_value, cyc});
      if (write) rf[reg_addr] <= write_value;
      else read_value <= rf[reg_addr];
    end
    if (new_req && prev_req) consec <= consec + 1;
    prev_req <= new_req;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    new_rx_data = 1'b1;
    last_strobe = cyc;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
    rx_data = 8'h00;
    tick(gap);
  endtask

  task automatic set_rf(input int a, input logic [7:0] v);
    pre_addr = a;
    pre_val = v;
    pre_go = 1'b1;
    @(negedge clk); #1;
    pre_go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] W(input int a, input logic [7:0] v);
    logic [5:0] a6;
    a6 = a[5:0];
    return {1'b1, a6, v};
  endfunction

  function automatic logic [14:0] R(input int a);
    logic [5:0] a6;
    a6 = a[5:0];
    return {1'b0, a6, 8'h00};
  endfunction

  function automatic logic [14:0] enc(input req_t r);
    return {r.wr, r.addr, r.wr ? r.val : 8'h00};
  endfunction

  // Message-level reference model.
  logic       m_ok = 1'b0;
  logic [7:0] m_st = 8'h00;
  logic [7:0] m_msg[$];
  logic [7:0] m_rf[64] = '{default: 8'h00};
  req_t       exp_q[$];

  task automatic model_byte(input logic [7:0] b);
    int need;
    int ch;
    logic [6:0] note;
    logic [6:0] vel;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_ok = 1'b0; m_msg.delete(); return; end
    if (b >= 8'h80) begin m_ok = 1'b1; m_st = b; m_msg.delete(); return; end
    if (!m_ok) return;
    m_msg.push_back(b);
    need = (m_st[7:5] == 3'b110) ? 1 : 2;
    if (m_msg.size() < need) return;
    ch = int'(m_st[3:0]);
    if ((m_st[7:4] == 4'h8 || m_st[7:4] == 4'h9) && ch < NUM_CH) begin
      note = m_msg[0][6:0];
      vel = m_msg[1][6:0];
      if (m_st[7:4] == 4'h9 && vel != 0) begin
        exp_q.push_back('{1'b1, 6'(ch), {1'b1, note}, 0});
        m_rf[ch] = {1'b1, note};
      end else begin
        exp_q.push_back('{1'b0, 6'(ch), 8'h00, 0});
        if (m_rf[ch] == {1'b1, note}) begin
          exp_q.push_back('{1'b1, 6'(ch), {1'b0, note}, 0});
          m_rf[ch] = {1'b0, note};
        end
      end
    end
    m_msg.delete();
  endtask

  typedef struct {
    int          n;
    logic [39:0] bytes;
    int          pre_a;
    logic [7:0]  pre_v;
    int          nreq;
    logic [14:0] r0;
    logic [14:0] r1;
    int          lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3, 40'h91407F0000, 0, 8'h00, 1, W(1, 8'hC0), 15'h0, 1};
    vt[1] = '{5, 40'h903C643E64, 0, 8'h00, 2, W(0, 8'hBC), W(0, 8'hBE), 1};
    vt[2] = '{3, 40'h803C000000, 0, 8'hBC, 2, R(0), W(0, 8'h3C), 3};
    vt[3] = '{3, 40'h803C000000, 0, 8'hBE, 1, R(0), 15'h0, 1};
    vt[4] = '{5, 40'h90F83CFE64, 0, 8'h00, 1, W(0, 8'hBC), 15'h0, 1};
    vt[5] = '{3, 40'h953C640000, 0, 8'h00, 0, 15'h0, 15'h0, 0};
    vt[6] = '{3, 40'hF03C640000, 0, 8'h00, 0, 15'h0, 15'h0, 0};
    vt[7] = '{3, 40'h9345000000, 3, 8'hC5, 2, R(3), W(3, 8'h45), 3};
    vt[8] = '{5, 40'hC010903C64, 0, 8'h00, 1, W(0, 8'hBC), 15'h0, 1};

    rst = 1'b0;
    tick(3);
    check("reset_outputs", {new_req, write, reg_addr, write_value, busy, overflow}, 32'h0);
    rst = 1'b1;
    tick(2);

    foreach (vt[k]) begin
      set_rf(vt[k].pre_a, vt[k].pre_v);
      obs_q.delete();
      for (int i = 0; i < vt[k].n; i++) send(vt[k].bytes[39 - 8*i -: 8], 4);
      tick(4);
      check($sformatf("vec%0d_nreq", k), obs_q.size(), vt[k].nreq);
      if (vt[k].nreq > 0 && obs_q.size() > 0) check($sformatf("vec%0d_req0", k), enc(obs_q[0]), vt[k].r0);
      if (vt[k].nreq > 1 && obs_q.size() > 1) check($sformatf("vec%0d_req1", k), enc(obs_q[1]), vt[k].r1);
      if (vt[k].lat > 0 && obs_q.size() > 0)
        check($sformatf("vec%0d_latency", k), obs_q[obs_q.size()-1].cyc - last_strobe, vt[k].lat);
      check($sformatf("vec%0d_overflow", k), overflow, 0);
    end

    // Two bytes land during RD_REQ and RD_CHK: first buffered, second dropped.
    set_rf(0, 8'h00);
    obs_q.delete();
    send(8'h80, 4);
    send(8'h3C, 4);
    send(8'h00, 0);
    check("busy_in_read", busy, 1);
    send(8'h90, 0);
    send(8'h3C, 0);
    tick(2);
    check("ovf_set", overflow, 1);
    send(8'h3E, 4);
    send(8'h64, 4);
    tick(4);
    check("ovf_nreq", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("ovf_read", enc(obs_q[0]), R(0));
      check("ovf_write", enc(obs_q[1]), W(0, 8'hBE));
    end
    check("ovf_sticky", overflow, 1);
    rst = 1'b0;
    tick(2);
    check("ovf_reset_outputs", {new_req, write, reg_addr, write_value, busy, overflow}, 32'h0);
    rst = 1'b1;
    tick(2);

    // Reset during a note-off read aborts the follow-up write.
    set_rf(0, 8'hBC);
    obs_q.delete();
    send(8'h80, 4);
    send(8'h3C, 4);
    send(8'h00, 0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(6);
    check("abort_nreq", obs_q.size(), 1);
    if (obs_q.size() == 1) check("abort_read", enc(obs_q[0]), R(0));
    check("abort_busy", busy, 0);
    send(8'h3C, 4);
    send(8'h64, 4);
    tick(4);
    check("abort_rs_invalid", obs_q.size(), 1);

    // Random stream, spaced so no byte is dropped.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    for (int a = 0; a < 6; a++) set_rf(a, 8'h00);
    for (int a = 0; a < 64; a++) m_rf[a] = 8'h00;
    m_ok = 1'b0;
    m_msg.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int r;
      int ch;
      r = $urandom_range(0, 19);
      ch = $urandom_range(0, 5);
      if (r <= 2) b = {4'h9, 4'(ch)};
      else if (r <= 4) b = {4'h8, 4'(ch)};
      else if (r == 5) b = {4'(12 + $urandom_range(0, 1)), 4'(ch)};
      else if (r == 6) b = {4'(10 + $urandom_range(0, 1)), 4'(ch)};
      else if (r == 7) b = 8'(8'hF0 + $urandom_range(0, 7));
      else if (r == 8) b = 8'(8'hF8 + $urandom_range(0, 7));
      else if (r <= 13) b = 8'(8'h3C + $urandom_range(0, 3));
      else if (r <= 15) b = 8'h00;
      else b = 8'($urandom_range(1, 127));
      model_byte(b);
      send(b, 3);
    end
    tick(6);
    check("rand_nreq", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("rand_req%0d", i), enc(obs_q[i]), enc(exp_q[i]));
    check("rand_overflow", overflow, 0);
    check("no_back_to_back_req", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_reg_master.md
MIDI_REG_MASTER -- requirements
Module: midi_reg_master

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4: number of MIDI channels mapped to floppy registers; channel n maps to reg_addr n.
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port rx_data, input, 8 bits: received MIDI byte, valid only while new_rx_data is high.
REQ-005 The block SHALL have port new_rx_data, input, 1 bit: one-cycle strobe, one byte per strobe.
REQ-006 The block SHALL have port reg_addr, output, 6 bits: register address for the current request.
REQ-007 The block SHALL have port write, output, 1 bit: 1 = write request, 0 = read request; meaningful only with new_req.
REQ-008 The block SHALL have port new_req, output, 1 bit: one-cycle request strobe.
REQ-009 The block SHALL have port write_value, output, 8 bits: write data, {enable, note[6:0]}.
REQ-010 The block SHALL have port read_value, input, 8 bits: responder read data, valid the cycle after a read new_req.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is outside IDLE.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-013 All outputs SHALL be registered; reg_addr, write and write_value SHALL hold their values between requests.
REQ-014 Bytes 0xF8-0xFF (realtime) SHALL be discarded at the input without changing parser state or the holding buffer.
REQ-015 Status bytes 0x80-0xEF SHALL load running status (type, channel, data count: 1 for 0xC0-0xDF, else 2) and clear the data index.
REQ-016 Status bytes 0xF0-0xF7 SHALL invalidate running status; subsequent data bytes SHALL be discarded until the next 0x80-0xEF status byte.
REQ-017 Messages other than note-on/note-off, and any message on channel >= NUM_CH, SHALL consume their data bytes and issue no request.
REQ-018 Running status SHALL persist after a message completes; a following data byte starts a new message with the same status.
REQ-019 FSM states SHALL be IDLE, RD_REQ, RD_CHK and WR_REQ; bytes SHALL be parsed only in IDLE.
REQ-020 A completed note-on with velocity 1-127 SHALL go IDLE -> WR_REQ with write_value = {1, note}.
REQ-021 A completed note-off (0x8n, any velocity) or note-on with velocity 0 SHALL go IDLE -> RD_REQ.
REQ-022 In RD_REQ the block SHALL pulse new_req with write=0 and reg_addr=channel, then go to RD_CHK next cycle.
REQ-023 In RD_CHK, if read_value[7]=1 and read_value[6:0]=note, the FSM SHALL go to WR_REQ with write_value = {0, note}; otherwise it SHALL return to IDLE with no write.
REQ-024 In WR_REQ the block SHALL pulse new_req with write=1 and reg_addr=channel, then return to IDLE.
REQ-025 Latency from the final data-byte strobe SHALL be 1 cycle to the new_req pulse for note-on, and 1 cycle to the read pulse plus 2 more cycles to the write pulse for a matching note-off.
REQ-026 A non-realtime byte arriving outside IDLE SHALL be stored in a 1-entry holding buffer; on return to IDLE the buffered byte SHALL be parsed before any new byte.
REQ-027 If the buffer is full and a new byte arrives outside IDLE, or a new byte arrives in IDLE on the same cycle the buffered byte is parsed, the new byte SHALL be dropped and overflow set.
REQ-028 new_req SHALL never be high on two consecutive cycles.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL return to IDLE, invalidate running status, empty the buffer and clear the data index, with new_req=0, write=0, reg_addr=0, write_value=0x00, busy=0 and overflow=0.
REQ-030 Reset asserted mid-request SHALL abort the request, with no further new_req pulses.

Verification
REQ-031 The bench SHALL check: 0x91,0x40,0x7F -> one new_req, write=1, reg_addr=1, write_value=0xC0.
REQ-032 The bench SHALL check: running status 0x90,0x3C,0x64,0x3E,0x64 -> two writes, values 0xBC then 0xBE, both at addr 0.
REQ-033 The bench SHALL check: 0x80,0x3C,0x00 with read_value=0xBC -> read at addr 0, then a write of 0x3C two cycles later; with read_value=0xBE -> read only, no write.
REQ-034 The bench SHALL check: 0x90,0xF8,0x3C,0xFE,0x64 -> single write 0xBC; realtime bytes have no effect.
REQ-035 The bench SHALL check: 0x95,0x3C,0x64 with NUM_CH=4 -> no new_req; then 0xF0,0x3C,0x64 -> no new_req.
REQ-036 The bench SHALL check: two bytes strobed back-to-back during RD_REQ/RD_CHK -> the first is buffered and parsed, the second is dropped, and overflow=1 until rst=0.
